reqack_monitor_mc: RTL and testbench



---
 rtl/reqack_monitor_mc.sv | 161 ++++++++++++++++
 tb/tb_reqack_monitor_mc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reqack_monitor_mc.sv
// Multi-channel req/ack protocol monitor: per-channel handshake FSM, latency timeout,
// sticky error status with interrupt. Optional REQACK_LAT_STATS_EN adds max_lat_seen.
module reqack_monitor_mc #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned MAX_LAT = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   ack,
  input  logic [N_CH-1:0]   clr_err,
  output logic [N_CH-1:0]   done,
  output logic [N_CH-1:0]   err_timeout,
  output logic [N_CH-1:0]   err_drop,
  output logic [N_CH-1:0]   err_spur,
  output logic              intrpt,
  output logic [CNT_W-1:0]  timeout_cnt
`ifdef REQACK_LAT_STATS_EN
  ,
  output logic [N_CH*8-1:0] max_lat_seen
`endif
);

  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
  localparam int unsigned POP_W = $clog2(N_CH + 1);
  localparam int unsigned SUM_W = CNT_W + POP_W;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_ERR} state_e;

  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [LAT_W-1:0] lat_q   [N_CH];
  logic [LAT_W-1:0] lat_d   [N_CH];

  logic [N_CH-1:0]  done_d, tmo_set, drop_set, spur_set;
  logic [N_CH-1:0]  done_q, tmo_q, drop_q, spur_q;
  logic             intrpt_q;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  // lat_q holds the index of the cycle currently being sampled while in WAIT
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i]  = state_q[i];
      lat_d[i]    = lat_q[i];
      done_d[i]   = 1'b0;
      tmo_set[i]  = 1'b0;
      drop_set[i] = 1'b0;
      spur_set[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (req[i]) begin
            lat_d[i] = LAT_W'(1);
            if (ack[i]) begin
              state_d[i] = S_HOLD;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = S_WAIT;
            end
          end else if (ack[i]) begin
            spur_set[i] = 1'b1;
          end
        end
        S_WAIT: begin
          if (ack[i]) begin
            state_d[i] = S_HOLD;
            done_d[i]  = 1'b1;
          end else if (!req[i]) begin
            state_d[i]  = S_IDLE;
            drop_set[i] = 1'b1;
          end else if (lat_q[i] == LAT_MAX) begin
            state_d[i] = S_ERR;
            tmo_set[i] = 1'b1;
          end else begin
            lat_d[i] = lat_q[i] + LAT_W'(1);
          end
        end
        S_HOLD, S_ERR: begin
          if (!req[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pop = pop + POP_W'(tmo_set[i]);
    end
    sum    = SUM_W'(tcnt_q) + SUM_W'(pop);
    tcnt_d = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        lat_q[i]   <= '0;
      end
      done_q   <= '0;
      tmo_q    <= '0;
      drop_q   <= '0;
      spur_q   <= '0;
      intrpt_q <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
      done_q   <= done_d;
      tmo_q    <= tmo_set  | (tmo_q  & ~clr_err);
      drop_q   <= drop_set | (drop_q & ~clr_err);
      spur_q   <= spur_set | (spur_q & ~clr_err);
      intrpt_q <= |{tmo_q, drop_q, spur_q};
      tcnt_q   <= tcnt_d;
    end
  end

  assign done        = done_q;
  assign err_timeout = tmo_q;
  assign err_drop    = drop_q;
  assign err_spur    = spur_q;
  assign intrpt      = intrpt_q;
  assign timeout_cnt = tcnt_q;

`ifdef REQACK_LAT_STATS_EN
  logic [7:0] maxlat_q [N_CH];
  logic [7:0] maxlat_d [N_CH];
  logic [7:0] acc_lat  [N_CH];

  // an ack taken straight from IDLE has latency 0; otherwise lat_q is the latency
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      acc_lat[i]  = (state_q[i] == S_WAIT) ? 8'(lat_q[i]) : 8'd0;
      maxlat_d[i] = maxlat_q[i];
      if (done_d[i] && (acc_lat[i] > maxlat_q[i])) maxlat_d[i] = acc_lat[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_CH; i++) maxlat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) maxlat_q[i] <= maxlat_d[i];
    end
  end

  always_comb begin
    max_lat_seen = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      max_lat_seen[i*8 +: 8] = maxlat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_reqack_monitor_mc.sv
// Directed self-checking bench for reqack_monitor_mc (default build and REQACK_LAT_STATS_EN).
module tb_reqack_monitor_mc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req, ack, clr_err;

  logic [3:0] done, err_timeout, err_drop, err_spur;
  logic       intrpt;
  logic [7:0] timeout_cnt;

  logic [3:0] done2, err_timeout2, err_drop2, err_spur2;
  logic       intrpt2;
  logic [1:0] timeout_cnt2;

`ifdef REQACK_LAT_STATS_EN
  logic [31:0] max_lat_seen, max_lat_seen2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reqack_monitor_mc #(.N_CH(4), .MAX_LAT(5), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .clr_err(clr_err),
    .done(done), .err_timeout(err_timeout), .err_drop(err_drop), .err_spur(err_spur),
    .intrpt(intrpt), .timeout_cnt(timeout_cnt)
`ifdef REQACK_LAT_STATS_EN
    , .max_lat_seen(max_lat_seen)
`endif
  );

  reqack_monitor_mc #(.N_CH(4), .MAX_LAT(5), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .clr_err(clr_err),
    .done(done2), .err_timeout(err_timeout2), .err_drop(err_drop2), .err_spur(err_spur2),
    .intrpt(intrpt2), .timeout_cnt(timeout_cnt2)
`ifdef REQACK_LAT_STATS_EN
    , .max_lat_seen(max_lat_seen2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0; ack = '0; clr_err = '0;
    tick(2);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'({err_timeout, err_drop, err_spur}), 0);
    check("rst_intrpt", 32'(intrpt), 0);
    check("rst_tcnt", 32'(timeout_cnt), 0);
    reset_n = 1'b1;

    // ch0: ack at cycle 3, done one cycle later
    req = 4'b0001;
    tick(3);
    check("t1_nodone_early", 32'(done), 0);
    ack = 4'b0001;
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_noerr", 32'({err_timeout, err_drop, err_spur}), 0);
`ifdef REQACK_LAT_STATS_EN
    check("t1_maxlat", 32'(max_lat_seen[7:0]), 3);
`endif
    req = '0; ack = '0;
    tick();
    check("t1_done_pulse", 32'(done), 0);

    // ch1: timeout
    req = 4'b0010;
    tick(5);
    check("t2_no_tmo_c5", 32'(err_timeout), 0);
    tick();
    check("t2_tmo", 32'(err_timeout), 32'h2);
    check("t2_tcnt", 32'(timeout_cnt), 1);
    check("t2_intrpt_lag", 32'(intrpt), 0);
    ack = 4'b0010;
    tick();
    check("t2_intrpt", 32'(intrpt), 1);
    check("t2_late_ack0", 32'(done), 0);
    tick();
    check("t2_late_ack1", 32'(done), 0);
    req = '0; ack = '0;
    tick();
    clr_err = 4'b0010;
    tick();
    clr_err = '0;
    check("t2_clr", 32'(err_timeout), 0);
    tick();
    check("t2_intrpt_clr", 32'(intrpt), 0);

    // ch2: req dropped before ack
    req = 4'b0100;
    tick(2);
    check("t3_no_drop", 32'(err_drop), 0);
    req = '0;
    tick();
    check("t3_drop", 32'(err_drop), 32'h4);
    req = 4'b0100; ack = 4'b0100;
    tick();
    check("t3_idle_done", 32'(done), 32'h4);
    check("t3_no_spur", 32'(err_spur), 0);
`ifdef REQACK_LAT_STATS_EN
    check("t3_maxlat", 32'(max_lat_seen[23:16]), 0);
`endif
    req = '0; ack = '0;
    tick();
    clr_err = 4'b0100;
    tick();
    clr_err = '0;
    check("t3_clr", 32'(err_drop), 0);

    // ch3: spurious ack, set beats clear
    ack = 4'b1000;
    tick();
    check("t4_spur", 32'(err_spur), 32'h8);
    ack = '0;
    tick();
    ack = 4'b1000; clr_err = 4'b1000;
    tick();
    check("t4_set_prio", 32'(err_spur), 32'h8);
    ack = '0; clr_err = '0;
    tick();
    check("t4_sticky", 32'(err_spur), 32'h8);
    clr_err = 4'b1000;
    tick();
    clr_err = '0;
    check("t4_clr", 32'(err_spur), 0);

    // all channels time out together
    req = 4'b1111;
    tick(6);
    check("t5_tmo_all", 32'(err_timeout), 32'hF);
    check("t5_tcnt", 32'(timeout_cnt), 5);
    check("t5_tcnt_sat", 32'(timeout_cnt2), 3);
    req = '0;
    tick();
    clr_err = 4'b1111;
    tick();
    clr_err = '0;
    req = 4'b0001;
    tick(6);
    check("t5_tcnt2", 32'(timeout_cnt), 6);
    check("t5_tcnt_sat2", 32'(timeout_cnt2), 3);
    req = '0;
    tick();

    // reset in WAIT with req held high
    req = 4'b0001;
    tick(2);
    check("t6_pre_intrpt", 32'(intrpt), 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_tmo", 32'(err_timeout), 0);
    check("t6_rst_intrpt", 32'(intrpt), 0);
    check("t6_rst_tcnt", 32'(timeout_cnt), 0);
    check("t6_rst_tcnt_sat", 32'(timeout_cnt2), 0);
    tick();
    reset_n = 1'b1;
    tick(5);
    check("t6_no_tmo", 32'(err_timeout), 0);
    ack = 4'b0001;
    tick();
    check("t6_done", 32'(done), 32'h1);
    check("t6_noerr", 32'({err_timeout, err_drop, err_spur}), 0);
`ifdef REQACK_LAT_STATS_EN
    check("t6_maxlat", 32'(max_lat_seen[7:0]), 5);
`endif
    req = '0; ack = '0;
    tick();
    check("t6_done_pulse", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
